// File: rtl/request_unit.sv
// request_unit: fetch/data request sequencer with halt latch and dhit watchdog; REQUEST_UNIT_PERF_EN adds perf counters
module request_unit #(
    parameter int DHIT_TIMEOUT = 255,
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             DatRead,
    input  logic             DatWrite,
    input  logic             Halt,
    input  logic             ihit,
    input  logic             dhit,
    output logic             imemREN,
    output logic             dmemREN,
    output logic             dmemWEN,
    output logic             pc_en,
    output logic             halt_out,
    output logic             timeout_err,
    output logic [CNT_W-1:0] retired_cnt,
    output logic [CNT_W-1:0] stall_cnt
);
    localparam logic [1:0] FETCH  = 2'd0;
    localparam logic [1:0] DATA   = 2'd1;
    localparam logic [1:0] HALTED = 2'd2;
    localparam logic [15:0] WLIM = 16'(DHIT_TIMEOUT - 1);
    logic [1:0] state, nxt;
    logic rd_q, wr_q, trap, fetch, data;
    logic [15:0] wdog;
    assign fetch = state == FETCH;
    assign data = state == DATA;
    assign trap = data && !dhit && wdog == WLIM;
    assign imemREN = fetch;
    assign dmemREN = data && rd_q;
    assign dmemWEN = data && wr_q;
    assign halt_out = state == HALTED;
    // Mealy retire pulse; gated so nothing retires while reset is held
    assign pc_en = nRST && (fetch ? ihit && !Halt && !DatRead && !DatWrite : data && dhit);
    always_comb begin
        nxt = state;
        if (fetch && ihit)
            nxt = Halt ? HALTED : (DatWrite || DatRead) ? DATA : FETCH;
        else if (data)
            nxt = dhit ? FETCH : trap ? HALTED : DATA;
    end
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= FETCH;
            rd_q <= 1'b0;
            wr_q <= 1'b0;
            wdog <= '0;
            timeout_err <= 1'b0;
        end else begin
            state <= nxt;
            if (fetch && ihit && !Halt) begin
                wr_q <= DatWrite;
                rd_q <= DatRead && !DatWrite;
            end else if (data && dhit) begin
                rd_q <= 1'b0;
                wr_q <= 1'b0;
            end
            wdog <= (!data || dhit) ? '0 : (&wdog) ? wdog : wdog + 16'd1;
            if (trap)
                timeout_err <= 1'b1;
        end
    end
`ifdef REQUEST_UNIT_PERF_EN
    logic stall;
    assign stall = (fetch && !ihit) || (data && !dhit);
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            retired_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            retired_cnt <= retired_cnt + CNT_W'(pc_en);
            stall_cnt <= stall_cnt + CNT_W'(stall);
        end
    end
`else
    assign retired_cnt = '0;
    assign stall_cnt = '0;
`endif
endmodule

// File: tb/tb_request_unit.sv
// tb_request_unit: directed plan sequences plus random traffic against a transaction-level model
module tb_request_unit;
    localparam int TO = 4;
    logic CLK, nRST, DatRead, DatWrite, Halt, ihit, dhit;
    logic imemREN, dmemREN, dmemWEN, pc_en, halt_out, timeout_err;
    logic [31:0] retired_cnt, stall_cnt;
    int n_vec = 0, n_err = 0;
    bit m_halt, m_tout;
    int m_op, m_wait;
    bit [31:0] m_ret, m_stall;

    request_unit #(.DHIT_TIMEOUT(TO), .CNT_W(32)) dut (
        .CLK(CLK), .nRST(nRST), .DatRead(DatRead), .DatWrite(DatWrite), .Halt(Halt),
        .ihit(ihit), .dhit(dhit), .imemREN(imemREN), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
        .pc_en(pc_en), .halt_out(halt_out), .timeout_err(timeout_err),
        .retired_cnt(retired_cnt), .stall_cnt(stall_cnt)
    );

    initial begin
        CLK = 0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic check_all(input bit im, input bit dr, input bit dw, input bit pc);
        chk("imemREN", imemREN, im);
        chk("dmemREN", dmemREN, dr);
        chk("dmemWEN", dmemWEN, dw);
        chk("pc_en", pc_en, pc);
        chk("halt_out", halt_out, m_halt);
        chk("timeout_err", timeout_err, m_tout);
`ifdef REQUEST_UNIT_PERF_EN
        chk("retired_cnt", retired_cnt, m_ret);
        chk("stall_cnt", stall_cnt, m_stall);
`else
        chk("retired_cnt", retired_cnt, 0);
        chk("stall_cnt", stall_cnt, 0);
`endif
    endtask

    // entered and left just after a falling edge
    task automatic rst();
        nRST = 0;
        #1;
        m_halt = 0; m_tout = 0; m_op = 0; m_wait = 0; m_ret = 0; m_stall = 0;
        check_all(1, 0, 0, 0);
        ihit = 0; Halt = 0; DatRead = 0; DatWrite = 0; dhit = 0;
        @(posedge CLK);
        @(negedge CLK);
        nRST = 1;
    endtask

    task automatic cycle(input bit i, input bit h, input bit r, input bit w, input bit d);
        bit fe, da, pc, st;
        ihit = i; Halt = h; DatRead = r; DatWrite = w; dhit = d;
        #1;
        fe = !m_halt && m_op == 0;
        da = !m_halt && m_op != 0;
        pc = fe ? (i && !h && !r && !w) : (da && d);
        st = (fe && !i) || (da && !d);
        check_all(fe, da && m_op == 1, da && m_op == 2, pc);
        @(posedge CLK);
        if (!m_halt) begin
            m_ret += 32'(pc);
            m_stall += 32'(st);
        end
        if (fe && i) begin
            if (h) m_halt = 1;
            else if (w) begin m_op = 2; m_wait = 0; end
            else if (r) begin m_op = 1; m_wait = 0; end
        end else if (da) begin
            if (d) m_op = 0;
            else if (++m_wait == TO) begin m_halt = 1; m_tout = 1; end
        end
        @(negedge CLK);
    endtask

    initial begin
        nRST = 1; ihit = 0; Halt = 0; DatRead = 0; DatWrite = 0; dhit = 0;
        @(negedge CLK);
        rst();
        repeat (4) cycle(1, 0, 0, 0, 0);
        rst();
        cycle(1, 0, 1, 0, 0);
        cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1);
        chk("load_retired", retired_cnt,
`ifdef REQUEST_UNIT_PERF_EN
            1);
`else
            0);
`endif
        cycle(0, 0, 0, 0, 0);
        cycle(1, 0, 1, 1, 0);
        cycle(0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 1);
        cycle(1, 1, 1, 0, 0);
        repeat (3) cycle(1, 0, 0, 0, 1);
        rst();
        cycle(1, 0, 0, 1, 0);
        repeat (4) cycle(0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 1);
        rst();
        cycle(1, 0, 0, 1, 0);
        repeat (3) cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1);
        cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 0);
        chk("mid_data_dmemREN", dmemREN, 1);
        rst();
        repeat (3000) begin
            if ((m_halt && $urandom_range(0, 3) == 0) || $urandom_range(0, 199) == 0)
                rst();
            else
                cycle($urandom_range(0, 1), $urandom_range(0, 31) == 0, $urandom_range(0, 3) == 0,
                      $urandom_range(0, 3) == 0, $urandom_range(0, 9) < 4);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
